// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: packet-type encodings, PID bytes and framer state constants
package usb_tx_pkg;

    localparam logic [2:0] PKT_DATA0 = 3'd1;
    localparam logic [2:0] PKT_DATA1 = 3'd2;
    localparam logic [2:0] PKT_ACK   = 3'd3;
    localparam logic [2:0] PKT_NAK   = 3'd4;
    localparam logic [2:0] PKT_STALL = 3'd5;

    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SYNC   = 3'd1;
    localparam state_t ST_PID    = 3'd2;
    localparam state_t ST_DATA   = 3'd3;
    localparam state_t ST_CRC_LO = 3'd4;
    localparam state_t ST_CRC_HI = 3'd5;
    localparam state_t ST_EOP    = 3'd6;

    function automatic logic [7:0] pid_of(input logic [2:0] p);
        return p == PKT_DATA0 ? PID_DATA0 :
               p == PKT_DATA1 ? PID_DATA1 :
               p == PKT_ACK   ? PID_ACK   :
               p == PKT_NAK   ? PID_NAK   :
               p == PKT_STALL ? PID_STALL : 8'h00;
    endfunction

    function automatic logic is_data(input logic [2:0] p);
        return p == PKT_DATA0 || p == PKT_DATA1;
    endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// usb_crc16_byte: one-byte update of the reflected CRC16-USB register (poly A001)
module usb_crc16_byte (
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    // fold the byte in LSB first, one polynomial step per bit
    always_comb begin
        crc_out = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++)
            crc_out = crc_out[0] ? (crc_out >> 1) ^ 16'hA001 : crc_out >> 1;
    end

endmodule

// File: rtl/usb_tx_framer.sv
// usb_tx_framer: builds SYNC/PID/DATA/CRC16/EOP byte stream for the USB serializer
module usb_tx_framer
    import usb_tx_pkg::*;
#(
    parameter int          MAX_PAYLOAD  = 64,
    parameter int          SIZE_W       = $clog2(MAX_PAYLOAD + 1),
    parameter logic [7:0]  SYNC_PATTERN = 8'h80
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              tx_start,
    input  logic [2:0]        tx_packet,
    input  logic [SIZE_W-1:0] tx_size,
    input  logic [7:0]        tx_packet_data,
    output logic              get_tx_packet_data,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              eop,
    input  logic              eop_done,
    input  logic              tx_abort,
    output logic              busy,
    output logic              tx_done,
    output logic              tx_error
);

    localparam logic [SIZE_W-1:0] MAX_SIZE = SIZE_W'(MAX_PAYLOAD);

    state_t            state_q, state_d;
    logic [SIZE_W-1:0] count_q, count_d;
    logic [15:0]       crc_q, crc_d, crc_next;
    logic [2:0]        pkt_q, pkt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              xfer;
    logic              start_ok;

    usb_crc16_byte u_crc (
        .crc_in  (crc_q),
        .data    (tx_packet_data),
        .crc_out (crc_next)
    );

    assign xfer     = byte_valid && byte_ready;
    assign start_ok = tx_packet != 3'd0 && tx_packet < 3'd6 && (!is_data(tx_packet) || tx_size <= MAX_SIZE);

    // byte-producing states; outputs depend on state only, so they hold while the serializer stalls
    always_comb begin
        byte_valid         = state_q inside {ST_SYNC, ST_PID, ST_DATA, ST_CRC_LO, ST_CRC_HI};
        byte_out           = state_q == ST_SYNC   ? SYNC_PATTERN :
                             state_q == ST_PID    ? pid_of(pkt_q) :
                             state_q == ST_DATA   ? tx_packet_data :
                             state_q == ST_CRC_LO ? ~crc_q[7:0] :
                             state_q == ST_CRC_HI ? ~crc_q[15:8] : 8'h00;
        get_tx_packet_data = state_q == ST_DATA && byte_ready;
        eop                = state_q == ST_EOP;
        busy               = state_q != ST_IDLE;
        tx_done            = done_q;
        tx_error           = err_q;
    end

    // next-state: byte states advance on a transfer, abort overrides everything but IDLE/EOP
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        crc_d   = crc_q;
        pkt_d   = pkt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE:
                if (tx_start) begin
                    if (start_ok) begin
                        state_d = ST_SYNC;
                        pkt_d   = tx_packet;
                        count_d = tx_size;
                        crc_d   = 16'hFFFF;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            ST_SYNC:
                if (xfer) state_d = ST_PID;
            ST_PID:
                if (xfer) state_d = !is_data(pkt_q) ? ST_EOP : count_q == '0 ? ST_CRC_LO : ST_DATA;
            ST_DATA:
                if (xfer) begin
                    count_d = count_q - 1'b1;
                    crc_d   = crc_next;
                    if (count_q == SIZE_W'(1)) state_d = ST_CRC_LO;
                end
            ST_CRC_LO:
                if (xfer) state_d = ST_CRC_HI;
            ST_CRC_HI:
                if (xfer) state_d = ST_EOP;
            ST_EOP:
                if (eop_done) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            default:
                state_d = ST_IDLE;
        endcase
        if (tx_abort && state_q != ST_IDLE && state_q != ST_EOP) state_d = ST_EOP;
    end

    // state registers; reset drops any packet in flight without EOP or done
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            crc_q   <= 16'hFFFF;
            pkt_q   <= 3'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            crc_q   <= crc_d;
            pkt_q   <= pkt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_usb_tx_framer.sv
// tb_usb_tx_framer: directed tests against a packet-level model of the framer
module tb_usb_tx_framer;

    logic       clk = 0;
    logic       n_rst = 0;
    logic       tx_start = 0;
    logic [2:0] tx_packet = 0;
    logic [6:0] tx_size = 0;
    logic [7:0] tx_packet_data;
    logic       get_tx_packet_data;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready = 1;
    logic       eop;
    logic       eop_done = 0;
    logic       tx_abort = 0;
    logic       busy, tx_done, tx_error;

    int checks = 0;
    int failures = 0;

    logic [7:0] payload [0:127];
    int pop_idx = 0;
    int base = 0;

    // model state: 0 idle, 1 sending bytes, 2 eop, 3 done pulse due (framer already idle)
    int phase = 0;
    int nxt;
    int xfer_idx = 0;
    int dlo = 0, dhi = 0;
    logic err_exp = 0;
    logic hold = 0;
    logic [7:0] hold_byte;
    logic xf;
    logic [15:0] c;
    logic [7:0] expq[$];
    logic [7:0] got[$];
    logic [7:0] want[$];

    usb_tx_framer dut (
        .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_packet(tx_packet), .tx_size(tx_size),
        .tx_packet_data(tx_packet_data), .get_tx_packet_data(get_tx_packet_data),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .eop(eop), .eop_done(eop_done), .tx_abort(tx_abort),
        .busy(busy), .tx_done(tx_done), .tx_error(tx_error)
    );

    always #5 clk = ~clk;

    assign tx_packet_data = payload[7'(pop_idx - base)];

    always @(posedge clk) if (get_tx_packet_data) pop_idx <= pop_idx + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic [15:0] crc_model(input int n);
        logic [15:0] r = 16'hFFFF;
        logic fb;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 8; b++) begin
                fb = r[0] ^ payload[i][b];
                r = r >> 1;
                if (fb) r = r ^ 16'hA001;
            end
        return r;
    endfunction

    function automatic logic [7:0] pid_model(input logic [2:0] p);
        case (p)
            3'd1: return 8'hC3;
            3'd2: return 8'h4B;
            3'd3: return 8'hD2;
            3'd4: return 8'h5A;
            default: return 8'h1E;
        endcase
    endfunction

    // compare process: every cycle, outputs against the packet-level model
    always @(negedge clk) begin
        if (!n_rst) begin
            chk("reset_outputs", {byte_out, byte_valid, eop, busy, tx_done, tx_error, get_tx_packet_data}, 0);
            phase = 0;
            expq.delete();
            err_exp = 0;
            hold = 0;
        end else begin
            xf = byte_valid && byte_ready;
            chk("busy", busy, phase == 1 || phase == 2);
            chk("byte_valid", byte_valid, phase == 1);
            chk("eop", eop, phase == 2);
            chk("tx_done", tx_done, phase == 3);
            chk("tx_error", tx_error, err_exp);
            chk("get", get_tx_packet_data, phase == 1 && xf && xfer_idx >= dlo && xfer_idx < dhi);
            if (hold && phase == 1) chk("hold_stable", byte_out, hold_byte);
            hold = phase == 1 && byte_valid && !byte_ready;
            hold_byte = byte_out;
            err_exp = 0;
            nxt = phase;
            if (phase == 0 || phase == 3) begin
                nxt = 0;
                if (tx_start) begin
                    if (tx_packet >= 1 && tx_packet <= 5 && (tx_packet > 2 || tx_size <= 64)) begin
                        expq = '{8'h80, pid_model(tx_packet)};
                        dlo = 2;
                        dhi = 2;
                        if (tx_packet <= 2) begin
                            for (int i = 0; i < int'(tx_size); i++) expq.push_back(payload[i]);
                            c = ~crc_model(int'(tx_size));
                            expq.push_back(c[7:0]);
                            expq.push_back(c[15:8]);
                            dhi = 2 + int'(tx_size);
                        end
                        xfer_idx = 0;
                        nxt = 1;
                    end else begin
                        err_exp = 1;
                    end
                end
            end else if (phase == 1) begin
                if (xf) begin
                    if (expq.size() == 0) chk("extra_byte", byte_out, 8'h00 ^ ~byte_out);
                    else chk("byte_out", byte_out, expq.pop_front());
                    got.push_back(byte_out);
                    xfer_idx++;
                    if (expq.size() == 0) nxt = 2;
                end
                if (tx_abort) begin
                    expq.delete();
                    nxt = 2;
                end
            end else if (phase == 2) begin
                if (eop_done) nxt = 3;
            end
            phase = nxt;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [2:0] p, input int s);
        tick();
        tx_packet = p;
        tx_size = 7'(s);
        tx_start = 1;
        tick();
        tx_start = 0;
    endtask

    task automatic wait_phase(input int p);
        int k = 0;
        while (phase != p && k < 400) begin
            tick();
            k++;
        end
        chk("wait_phase", phase, p);
    endtask

    task automatic wait_idx(input int n);
        int k = 0;
        while (!(phase == 1 && xfer_idx >= n) && k < 400) begin
            tick();
            k++;
        end
        chk("wait_idx", xfer_idx >= n, 1);
    endtask

    task automatic finish_eop;
        wait_phase(2);
        tick();
        tick();
        eop_done = 1;
        tick();
        eop_done = 0;
        wait_phase(0);
    endtask

    task automatic chk_seq(input string n);
        chk({n, "_len"}, got.size(), want.size());
        for (int i = 0; i < want.size() && i < got.size(); i++) chk(n, got[i], want[i]);
    endtask

    task automatic begin_pkt;
        got.delete();
        base = pop_idx;
    endtask

    initial begin
        #5;
        chk("reset_state", {byte_out, byte_valid, eop, busy, tx_done, tx_error, get_tx_packet_data}, 0);
        tick();
        tick();
        n_rst = 1;
        tick();

        // DATA0, empty payload: CRC of nothing is ~FFFF = 0000
        begin_pkt();
        start(3'd1, 0);
        chk("latency_valid", byte_valid, 1);
        chk("latency_sync", byte_out, 8'h80);
        finish_eop();
        want = '{8'h80, 8'hC3, 8'h00, 8'h00};
        chk_seq("data0_empty");

        // DATA1 "123456789" with a second start ignored mid-packet
        for (int i = 0; i < 9; i++) payload[i] = 8'h31 + 8'(i);
        chk("crc_model_pin", crc_model(9), 16'h4B37);
        begin_pkt();
        start(3'd2, 9);
        wait_idx(4);
        start(3'd3, 0);
        finish_eop();
        want = '{8'h80, 8'h4B, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
        chk_seq("data1_check");
        chk("data1_pops", pop_idx - base, 9);

        // ACK with a 3-cycle stall on the PID byte
        begin_pkt();
        start(3'd3, 0);
        wait_idx(1);
        byte_ready = 0;
        tick();
        chk("ack_hold", byte_out, 8'hD2);
        tick();
        tick();
        byte_ready = 1;
        finish_eop();
        want = '{8'h80, 8'hD2};
        chk_seq("ack");

        // oversize DATA and illegal types are rejected
        start(3'd1, 65);
        chk("oversize_err", tx_error, 1);
        chk("oversize_valid", byte_valid, 0);
        tick();
        chk("err_pulse_one", tx_error, 0);
        start(3'd0, 0);
        chk("type0_err", tx_error, 1);
        start(3'd6, 0);
        start(3'd7, 0);
        chk("type7_err", tx_error, 1);
        tick();

        // handshake size is irrelevant; DATA at exactly MAX_PAYLOAD is legal
        begin_pkt();
        start(3'd4, 100);
        finish_eop();
        want = '{8'h80, 8'h5A};
        chk_seq("nak_big_size");
        begin_pkt();
        start(3'd5, 0);
        finish_eop();
        want = '{8'h80, 8'h1E};
        chk_seq("stall");
        for (int i = 0; i < 64; i++) payload[i] = 8'(i * 3 + 1);
        begin_pkt();
        start(3'd2, 64);
        finish_eop();
        chk("max_pops", pop_idx - base, 64);
        chk("max_len", got.size(), 68);

        // abort on the 3rd data byte of a 10-byte packet
        for (int i = 0; i < 10; i++) payload[i] = 8'hA0 + 8'(i);
        begin_pkt();
        start(3'd1, 10);
        wait_idx(4);
        tx_abort = 1;
        tick();
        tx_abort = 0;
        chk("abort_eop", eop, 1);
        chk("abort_valid", byte_valid, 0);
        finish_eop();
        chk("abort_pops", pop_idx - base <= 3, 1);
        want = '{8'h80, 8'hC3, 8'hA0, 8'hA1, 8'hA2};
        chk_seq("abort");

        // reset while CRC_LO is on the bus, then a clean packet with a toggling ready
        for (int i = 0; i < 4; i++) payload[i] = 8'h10 + 8'(i);
        begin_pkt();
        start(3'd1, 4);
        begin
            int k = 0;
            while (!(phase == 1 && expq.size() == 2) && k < 100) begin
                tick();
                k++;
            end
        end
        chk("reached_crc_lo", expq.size(), 2);
        n_rst = 0;
        #1;
        chk("async_reset", {byte_out, byte_valid, eop, busy, tx_done, tx_error, get_tx_packet_data}, 0);
        tick();
        tick();
        n_rst = 1;
        payload[0] = 8'hAA;
        payload[1] = 8'h55;
        payload[2] = 8'h0F;
        begin_pkt();
        start(3'd1, 3);
        begin
            int k = 0;
            while (phase != 2 && k < 100) begin
                byte_ready = ~byte_ready;
                tick();
                k++;
            end
        end
        byte_ready = 1;
        finish_eop();
        chk("post_reset_len", got.size(), 7);
        chk("post_reset_pops", pop_idx - base, 3);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usb_tx_framer.md
USB_TX_FRAMER -- requirements
Module: usb_tx_framer

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD, default 64, meaning the largest data payload in bytes.
REQ-002 SHALL have parameter SIZE_W, default $clog2(MAX_PAYLOAD+1), meaning the width of the size fields.
REQ-003 SHALL have parameter SYNC_PATTERN, default 8'h80, meaning the sync byte (LSB transmitted first).
REQ-004 clk  input  1  clock; all state changes on posedge.
REQ-005 n_rst  input  1  asynchronous, active-low reset.
REQ-006 tx_start  input  1  one-cycle request to begin a packet.
REQ-007 tx_packet  input  3  packet type sampled with tx_start: 1=DATA0, 2=DATA1, 3=ACK, 4=NAK, 5=STALL; 0, 6 and 7 are illegal.
REQ-008 tx_size  input  SIZE_W  payload byte count, sampled with tx_start.
REQ-009 tx_packet_data  input  8  payload byte, first-word-fall-through; valid whenever a data byte is owed.
REQ-010 get_tx_packet_data  output  1  pops the payload source; high in the same cycle the payload byte is accepted.
REQ-011 byte_out  output  8  byte to the serializer.
REQ-012 byte_valid  output  1  byte_out is valid.
REQ-013 byte_ready  input  1  serializer accepts byte_out; held low while the serializer is bit stuffing.
REQ-014 eop  output  1  requests end-of-packet signalling.
REQ-015 eop_done  input  1  the serializer has finished the EOP.
REQ-016 tx_abort  input  1  forces the framer to end the current packet.
REQ-017 busy, tx_done, tx_error  output  1 each  framer active; one-cycle packet-complete pulse; one-cycle rejected-request pulse.

Function
REQ-018 A byte transfer SHALL occur only in a cycle where byte_valid and byte_ready are both high.
REQ-019 While byte_valid is high and byte_ready is low, byte_out SHALL be held unchanged.
REQ-020 States SHALL be IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP; each byte state SHALL advance only on a transfer.
REQ-021 IDLE SHALL go to SYNC on a tx_start with a legal type and, for DATA types, tx_size <= MAX_PAYLOAD.
REQ-022 Any other tx_start in IDLE SHALL pulse tx_error and leave the framer in IDLE.
REQ-023 Latency SHALL be: tx_start in cycle N gives byte_valid=1 with byte_out=SYNC_PATTERN in cycle N+1.
REQ-024 The PID byte SHALL be DATA0=C3, DATA1=4B, ACK=D2, NAK=5A, STALL=1E (hex).
REQ-025 From PID, handshake types (ACK, NAK, STALL) SHALL go to EOP.
REQ-026 From PID, DATA types SHALL go to DATA, or to CRC_LO if the size is 0.
REQ-027 In DATA, byte_out SHALL equal tx_packet_data, and get_tx_packet_data SHALL equal the transfer condition.
REQ-028 In DATA, a remaining-byte counter loaded from tx_size SHALL decrement per transfer; DATA SHALL go to CRC_LO on the transfer at count 1.
REQ-029 CRC SHALL be CRC16-USB: reflected polynomial A001, initialised to FFFF at tx_start, updated once per data transfer.
REQ-030 The transmitted CRC SHALL be the complement of the register, sent as CRC_LO = bits [7:0] then CRC_HI = bits [15:8].
REQ-031 CRC_HI SHALL go to EOP.
REQ-032 In EOP, byte_valid SHALL be 0 and eop SHALL be 1 until eop_done is sampled high.
REQ-033 On leaving EOP, the framer SHALL go to IDLE and pulse tx_done in the same cycle.
REQ-034 tx_abort in any state other than IDLE or EOP SHALL force EOP in the next cycle, drop byte_valid, and issue no further pops; the CRC is not sent.
REQ-035 tx_start while busy SHALL be ignored, and no tx_error SHALL be raised.
REQ-036 If tx_abort and a transfer occur in the same cycle, the transfer SHALL complete and the abort SHALL still win the next-state decision.
REQ-037 busy SHALL be 1 in every state except IDLE.

Reset
REQ-038 On n_rst low, the state SHALL be IDLE and every output SHALL be 0 (byte_out = 00); the counter SHALL be 0 and the CRC register FFFF.
REQ-039 Reset asserted mid-packet SHALL abandon the packet immediately, without an EOP or tx_done.

Structure
REQ-040 Package usb_tx_pkg SHALL hold the tx_packet encodings, the PID constants and the state enum.
REQ-041 Sub-module usb_crc16_byte SHALL be a combinational byte-wise CRC16 update, instantiated once.

Verification
REQ-042 DATA0, size 0, byte_ready always 1 -> bytes 80, C3, 00, 00, then eop; tx_done after eop_done.
REQ-043 DATA1, size 9, payload "123456789" -> 80, 4B, 31..39, C8, B4; exactly 9 pops.
REQ-044 ACK, with byte_ready low for 3 cycles during the PID byte -> D2 held stable for those cycles; byte order 80, D2, then EOP.
REQ-045 DATA0, size MAX_PAYLOAD+1 -> tx_error pulse, byte_valid stays 0; a second tx_start mid-packet is ignored.
REQ-046 tx_abort during the 3rd data byte of a size-10 packet -> eop next cycle, total pops <= 3, no CRC bytes sent.
REQ-047 n_rst pulsed low during CRC_LO -> all outputs 0 at once; the next packet sent correctly after release.
